// File: rtl/rv32_tlb_walker.sv
// RV32 address translation: fully associative TLB backed by a hardware walker over a flat
// page table, with R/W/X permission checking, flush, round-robin refill and a bypass mode.
module rv32_tlb_walker #(
    parameter int NUM_ENTRIES = 8,
    parameter int PAGE_BITS   = 12,
    parameter int PPN_W       = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       flush_i,
    input  logic [31:0]                ptbase_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [31:0]                req_va_i,
    input  logic [1:0]                 req_acc_i,
    output logic                       resp_valid_o,
    output logic [PPN_W+PAGE_BITS-1:0] resp_pa_o,
    output logic                       resp_fault_o,
    output logic                       pt_req_valid_o,
    input  logic                       pt_req_ready_i,
    output logic [31:0]                pt_req_addr_o,
    input  logic                       pt_resp_valid_i,
    input  logic [31:0]                pt_resp_data_i
);

    // state     | meaning
    // IDLE      | ready for a request; bypass requests go straight to RESP
    // LOOKUP    | compare the VPN against all valid TLB tags
    // WALK_REQ  | PTE read request held until the memory accepts it
    // WALK_WAIT | waiting for PTE data, then check permissions and refill
    // RESP      | one-cycle response pulse

    localparam int VPN_W = 32 - PAGE_BITS;
    localparam int PA_W  = PPN_W + PAGE_BITS;
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WALK_REQ,
        S_WALK_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       va_q, va_d;
    logic [1:0]        acc_q, acc_d;
    logic [31:0]       ptaddr_q, ptaddr_d;
    logic [PA_W-1:0]   pa_q, pa_d;
    logic              fault_q, fault_d;

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]       tag_q  [NUM_ENTRIES];
    logic [PPN_W-1:0]       ppn_q  [NUM_ENTRIES];
    logic [2:0]             perm_q [NUM_ENTRIES];
    logic [IDX_W-1:0]       victim_q;

    logic [VPN_W-1:0]     va_vpn;
    logic [PAGE_BITS-1:0] va_off;
    logic                 hit, has_free, fill_en, pte_fault;
    logic [IDX_W-1:0]     hit_idx, free_idx, fill_idx;
    logic [2:0]           pte_perm;
    logic [PPN_W-1:0]     pte_ppn;
    logic                 unused_pte;

    // perm is {X, W, R}; access code 11 is checked as a read
    function automatic logic perm_ok(input logic [1:0] acc, input logic [2:0] perm);
        case (acc)
            2'b01:   return perm[1];
            2'b10:   return perm[2];
            default: return perm[0];
        endcase
    endfunction

    assign va_vpn     = va_q[31:PAGE_BITS];
    assign va_off     = va_q[PAGE_BITS-1:0];
    assign pte_perm   = pt_resp_data_i[3:1];
    assign pte_ppn    = pt_resp_data_i[10 +: PPN_W];
    assign pte_fault  = !pt_resp_data_i[0] || (pt_resp_data_i[2] && !pt_resp_data_i[1]) ||
                        !perm_ok(acc_q, pte_perm);
    assign unused_pte = ^pt_resp_data_i[9:4];

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == va_vpn) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Downward scan so the lowest-index invalid entry wins
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign fill_idx = has_free ? free_idx : victim_q;

    always_comb begin
        state_d  = state_q;
        va_d     = va_q;
        acc_d    = acc_q;
        ptaddr_d = ptaddr_q;
        pa_d     = pa_q;
        fault_d  = fault_q;
        fill_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    va_d  = req_va_i;
                    acc_d = req_acc_i;
                    if (en_i) begin
                        state_d = S_LOOKUP;
                    end else begin
                        state_d = S_RESP;
                        pa_d    = PA_W'(req_va_i);
                        fault_d = 1'b0;
                    end
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    state_d = S_RESP;
                    fault_d = !perm_ok(acc_q, perm_q[hit_idx]);
                    pa_d    = fault_d ? '0 : {ppn_q[hit_idx], va_off};
                end else begin
                    state_d  = S_WALK_REQ;
                    ptaddr_d = ptbase_i + 32'({va_vpn, 2'b00});
                end
            end
            S_WALK_REQ: begin
                if (pt_req_ready_i) state_d = S_WALK_WAIT;
            end
            S_WALK_WAIT: begin
                if (pt_resp_valid_i) begin
                    state_d = S_RESP;
                    fault_d = pte_fault;
                    pa_d    = pte_fault ? '0 : {pte_ppn, va_off};
                    // A flush in the fill cycle wins: the translation is returned but not kept
                    fill_en = !pte_fault && !flush_i;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            va_q     <= '0;
            acc_q    <= '0;
            ptaddr_q <= '0;
            pa_q     <= '0;
            fault_q  <= 1'b0;
            valid_q  <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            va_q     <= va_d;
            acc_q    <= acc_d;
            ptaddr_q <= ptaddr_d;
            pa_q     <= pa_d;
            fault_q  <= fault_d;
            if (flush_i) valid_q <= '0;
            else if (fill_en) valid_q[fill_idx] <= 1'b1;
            if (fill_en && !has_free) victim_q <= victim_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= va_vpn;
            ppn_q[fill_idx]  <= pte_ppn;
            perm_q[fill_idx] <= pte_perm;
        end
    end

    assign req_ready_o    = (state_q == S_IDLE);
    assign resp_valid_o   = (state_q == S_RESP);
    assign resp_pa_o      = pa_q;
    assign resp_fault_o   = fault_q;
    assign pt_req_valid_o = (state_q == S_WALK_REQ);
    assign pt_req_addr_o  = ptaddr_q;

endmodule

// File: tb/tb_rv32_tlb_walker.sv
// Self-checking bench for rv32_tlb_walker: a page-table memory model answers walks and a
// scoreboard of expected responses is checked as each response pulse appears.
module tb_rv32_tlb_walker;

    logic        clk = 1'b0;
    logic        rst, en, flush;
    logic [31:0] ptbase;
    logic        req_valid, req_ready;
    logic [31:0] req_va;
    logic [1:0]  req_acc;
    logic        resp_valid, resp_fault;
    logic [33:0] resp_pa;
    logic        pt_req_valid, pt_req_ready;
    logic [31:0] pt_req_addr;
    logic        pt_resp_valid;
    logic [31:0] pt_resp_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [33:0] pa;
        logic        fault;
    } exp_t;
    exp_t sb[$];

    logic [31:0] pt_mem [bit [31:0]];

    always #5 clk = ~clk;

    rv32_tlb_walker dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en),
        .flush_i        (flush),
        .ptbase_i       (ptbase),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_va_i       (req_va),
        .req_acc_i      (req_acc),
        .resp_valid_o   (resp_valid),
        .resp_pa_o      (resp_pa),
        .resp_fault_o   (resp_fault),
        .pt_req_valid_o (pt_req_valid),
        .pt_req_ready_i (pt_req_ready),
        .pt_req_addr_o  (pt_req_addr),
        .pt_resp_valid_i(pt_resp_valid),
        .pt_resp_data_i (pt_resp_data)
    );

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One request; expected result is derived from the page-table model and pushed before driving.
    task automatic do_req(input logic [31:0] va, input logic [1:0] acc, input logic en_v,
                          input logic exp_walk, input logic flush_with_resp, input string name);
        exp_t        e, got_e;
        logic [31:0] exp_addr, pte;
        logic        permok, walked, got;
        int          n, lat, wst, stall, cnt;
        exp_addr = ptbase + {10'd0, va[31:12], 2'b00};
        pte      = pt_mem.exists(exp_addr) ? pt_mem[exp_addr] : 32'h0;
        if (!en_v) begin
            e.pa    = {2'b00, va};
            e.fault = 1'b0;
        end else begin
            case (acc)
                2'b01:   permok = pte[2];
                2'b10:   permok = pte[3];
                default: permok = pte[1];
            endcase
            e.fault = !pte[0] || (pte[2] && !pte[1]) || !permok;
            e.pa    = e.fault ? 34'h0 : {pte[31:10], va[11:0]};
        end
        sb.push_back(e);

        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        req_valid = 1'b1;
        req_va    = va;
        req_acc   = acc;
        en        = en_v;
        @(posedge clk);
        n = 0; got = 0; walked = 0; wst = 0; stall = 0; lat = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            req_valid     = 1'b0;
            pt_resp_valid = 1'b0;
            flush         = 1'b0;
            if (resp_valid === 1'b1) begin
                got   = 1;
                lat   = n;
                got_e = sb.pop_front();
                n_cmp++;
                if (resp_pa !== got_e.pa) begin
                    n_bad++;
                    $display("FAIL %s pa: got %h expected %h", name, resp_pa, got_e.pa);
                end
                n_cmp++;
                if (resp_fault !== got_e.fault) begin
                    n_bad++;
                    $display("FAIL %s fault: got %b expected %b", name, resp_fault, got_e.fault);
                end
            end
            if (pt_req_valid === 1'b1) begin
                n_cmp++;
                if (pt_req_addr !== exp_addr) begin
                    n_bad++;
                    $display("FAIL %s pt_req_addr (%s): got %h expected %h", name,
                             walked ? "held" : "first", pt_req_addr, exp_addr);
                end
                walked = 1;
                if (stall == 0) begin
                    stall        = 1;
                    pt_req_ready = 1'b0;
                end else begin
                    pt_req_ready = 1'b1;
                    wst          = 3;
                end
            end else begin
                pt_req_ready = 1'b0;
                if (wst > 0) begin
                    wst--;
                    if (wst == 1) begin
                        pt_resp_valid = 1'b1;
                        pt_resp_data  = pte;
                        flush         = flush_with_resp;
                    end
                end
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no resp_valid after %0d cycles, expected a response", name, n);
            if (sb.size() > 0) got_e = sb.pop_front();
        end else begin
            n_cmp++;
            if (walked !== exp_walk) begin
                n_bad++;
                $display("FAIL %s walk: got %b expected %b", name, walked, exp_walk);
            end
            if (!exp_walk) begin
                n_cmp++;
                if (lat != (en_v ? 2 : 1)) begin
                    n_bad++;
                    $display("FAIL %s latency: got %0d expected %0d", name, lat, en_v ? 2 : 1);
                end
            end
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s after_pulse: got valid=%b ready=%b expected valid=0 ready=1",
                         name, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)     begin n_bad++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0)    begin n_bad++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (resp_pa !== 34'h0)      begin n_bad++; $display("FAIL rst_resp_pa: got %h expected 0", resp_pa); end
        n_cmp++; if (resp_fault !== 1'b0)    begin n_bad++; $display("FAIL rst_resp_fault: got %b expected 0", resp_fault); end
        n_cmp++; if (pt_req_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_pt_req_valid: got %b expected 0", pt_req_valid); end
        n_cmp++; if (pt_req_addr !== 32'h0)  begin n_bad++; $display("FAIL rst_pt_req_addr: got %h expected 0", pt_req_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        do_req(32'h1234_5678, 2'b00, 1'b0, 1'b0, 1'b0, "bypass_rd");
        do_req(32'hFFFF_F001, 2'b10, 1'b0, 1'b0, 1'b0, "bypass_ex");
    endtask

    task automatic test_walk_hit();
        ptbase            = 32'h0000_8000;
        pt_mem[32'h800C]  = 32'h0001_2C07;
        do_req(32'h0000_3ABC, 2'b00, 1'b1, 1'b1, 1'b0, "walk_rd");
        do_req(32'h0000_3ABC, 2'b00, 1'b1, 1'b0, 1'b0, "hit_rd");
        do_req(32'h0000_3004, 2'b01, 1'b1, 1'b0, 1'b0, "hit_wr");
        do_req(32'h0000_3FF0, 2'b10, 1'b1, 1'b0, 1'b0, "hit_ex_fault");
    endtask

    task automatic test_fault_not_cached();
        pt_mem[32'h8014] = 32'h0003_0006;
        pt_mem[32'h8018] = 32'h0004_0005;
        do_req(32'h0000_5010, 2'b00, 1'b1, 1'b1, 1'b0, "v0_fault");
        do_req(32'h0000_5010, 2'b00, 1'b1, 1'b1, 1'b0, "v0_rewalk");
        do_req(32'h0000_6020, 2'b01, 1'b1, 1'b1, 1'b0, "wnr_fault");
        do_req(32'h0000_6020, 2'b00, 1'b1, 1'b1, 1'b0, "wnr_rewalk");
    endtask

    task automatic test_perm_hit();
        pt_mem[32'h801C] = 32'h00AB_C003;
        do_req(32'h0000_7FFF, 2'b00, 1'b1, 1'b1, 1'b0, "ro_walk");
        do_req(32'h0000_7123, 2'b01, 1'b1, 1'b0, 1'b0, "ro_wr_fault");
        do_req(32'h0000_7456, 2'b11, 1'b1, 1'b0, 1'b0, "ro_acc11");
    endtask

    task automatic test_flush_mid_walk();
        pt_mem[32'h8080] = 32'h0000_0C0F;
        pt_mem[32'h8084] = 32'h0001_5403;
        do_req(32'h0002_0123, 2'b00, 1'b1, 1'b1, 1'b0, "fl_a_walk");
        do_req(32'h0002_0124, 2'b10, 1'b1, 1'b0, 1'b0, "fl_a_hit");
        do_req(32'h0002_1456, 2'b00, 1'b1, 1'b1, 1'b1, "fl_b_flush");
        do_req(32'h0002_1456, 2'b00, 1'b1, 1'b1, 1'b0, "fl_b_rewalk");
        do_req(32'h0002_0123, 2'b00, 1'b1, 1'b1, 1'b0, "fl_a_rewalk");
    endtask

    task automatic test_replacement();
        pulse_rst();
        for (int i = 0; i < 9; i++) begin
            pt_mem[ptbase + 32'((32'h100 + i) * 4)] = ((32'h200 + i) << 10) | 32'h3;
            do_req(((32'h100 + i) << 12) | 32'(i), 2'b00, 1'b1, 1'b1, 1'b0, "rr_fill");
        end
        do_req(32'h0010_0010, 2'b00, 1'b1, 1'b1, 1'b0, "rr_first_evicted");
        do_req(32'h0010_2020, 2'b00, 1'b1, 1'b0, 1'b0, "rr_third_hit");
        do_req(32'h0010_8030, 2'b00, 1'b1, 1'b0, 1'b0, "rr_ninth_hit");
        do_req(32'h0010_1040, 2'b00, 1'b1, 1'b1, 1'b0, "rr_second_evicted");
        do_req(32'h0010_0050, 2'b00, 1'b1, 1'b0, 1'b0, "rr_first_hit");
    endtask

    task automatic test_rst_mid_walk();
        logic seen;
        int   cnt;
        pt_mem[ptbase + 32'h0C00] = 32'h0007_7C03;
        // stray PTE data while idle must not produce a response
        pt_resp_valid = 1'b1;
        pt_resp_data  = 32'h0007_7C03;
        @(negedge clk);
        pt_resp_valid = 1'b0;
        req_valid = 1'b1;
        req_va    = 32'h0030_0000;
        req_acc   = 2'b00;
        en        = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        while (pt_req_valid !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (pt_req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rstw_walk_start: got pt_req_valid=%b expected 1", pt_req_valid);
        end
        pt_req_ready = 1'b1;
        @(negedge clk);
        pt_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        pt_resp_valid = 1'b1;
        @(negedge clk);
        pt_resp_valid = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            if (resp_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b0)         begin n_bad++; $display("FAIL rstw_no_resp: got resp seen=%b expected 0", seen); end
        n_cmp++; if (req_ready !== 1'b1)    begin n_bad++; $display("FAIL rstw_ready: got %b expected 1", req_ready); end
        n_cmp++; if (pt_req_valid !== 1'b0) begin n_bad++; $display("FAIL rstw_pt_req: got %b expected 0", pt_req_valid); end
        n_cmp++; if (sb.size() != 0)        begin n_bad++; $display("FAIL rstw_sb_empty: got %0d expected 0", sb.size()); end
        do_req(32'h0030_0ABC, 2'b00, 1'b1, 1'b1, 1'b0, "rstw_rewalk");
    endtask

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        flush         = 1'b0;
        ptbase        = 32'h0;
        req_valid     = 1'b0;
        req_va        = 32'h0;
        req_acc       = 2'b00;
        pt_req_ready  = 1'b0;
        pt_resp_valid = 1'b0;
        pt_resp_data  = 32'h0;
        test_reset();
        test_bypass();
        test_walk_hit();
        test_fault_not_cached();
        test_perm_hit();
        test_flush_mid_walk();
        test_replacement();
        test_rst_mid_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
